// File: rtl/slurm32_cpu_hazard_pipeline.sv
// slurm32_cpu_hazard_pipeline: carries stage-0 hazard tags (hazard_reg0/modifies_flags0) through stages 1..3 as hazard_reg1..3/modifies_flags1..3; hazard_1..3, mem_stall and flush steer stall, bubble and flush; outputs pipeline_stall, bubble_inserted, stall_state (0 RUN/1 HAZ/2 MEM), hazard_stall_count
module slurm32_cpu_hazard_pipeline #(
  parameter int REG_BITS = 8,
  parameter int CNT_BITS = 16
) (
  input  logic                CLK,
  input  logic                RSTb,
  input  logic [REG_BITS-1:0] hazard_reg0,
  input  logic                modifies_flags0,
  input  logic                hazard_1,
  input  logic                hazard_2,
  input  logic                hazard_3,
  input  logic                mem_stall,
  input  logic                flush,
  output logic [REG_BITS-1:0] hazard_reg1,
  output logic [REG_BITS-1:0] hazard_reg2,
  output logic [REG_BITS-1:0] hazard_reg3,
  output logic                modifies_flags1,
  output logic                modifies_flags2,
  output logic                modifies_flags3,
  output logic                pipeline_stall,
  output logic                bubble_inserted,
  output logic [1:0]          stall_state,
  output logic [CNT_BITS-1:0] hazard_stall_count
);
  localparam logic [1:0] RUN = 2'd0, HAZ = 2'd1, MEM = 2'd2;
  logic [1:0] state, state_nxt;
  logic hz_any, hz_take;
  assign hz_any  = hazard_1 | hazard_2 | hazard_3;
  assign hz_take = hz_any & ~flush;
  always_ff @(posedge CLK)
    if (!RSTb) state <= RUN;
    else state <= state_nxt;
  always_comb state_nxt = mem_stall ? MEM : flush ? RUN : hz_any ? HAZ : RUN;
  always_comb begin
    stall_state    = state;
    pipeline_stall = mem_stall | hz_take;
  end
  always_ff @(posedge CLK)
    if (!RSTb) begin
      hazard_reg1        <= '0;
      hazard_reg2        <= '0;
      hazard_reg3        <= '0;
      modifies_flags1    <= 1'b0;
      modifies_flags2    <= 1'b0;
      modifies_flags3    <= 1'b0;
      bubble_inserted    <= 1'b0;
      hazard_stall_count <= '0;
    end else if (!mem_stall) begin
      hazard_reg1        <= (flush | hz_any) ? '0 : hazard_reg0;
      modifies_flags1    <= (flush | hz_any) ? 1'b0 : modifies_flags0;
      hazard_reg2        <= flush ? '0 : hazard_reg1;
      modifies_flags2    <= flush ? 1'b0 : modifies_flags1;
      hazard_reg3        <= hazard_reg2;
      modifies_flags3    <= modifies_flags2;
      bubble_inserted    <= hz_take;
      hazard_stall_count <= (hz_take & ~&hazard_stall_count) ? hazard_stall_count + 1'b1 : hazard_stall_count;
    end
endmodule

// File: tb/tb_slurm32_cpu_hazard_pipeline.sv
// tb_slurm32_cpu_hazard_pipeline: randomized + directed scoreboard bench against a queue-based reference model
module tb_slurm32_cpu_hazard_pipeline;
  localparam int RB = 8, CB = 4;
  typedef struct {
    int unsigned r1, r2, r3, f1, f2, f3, bub, st, cnt, stall;
    int cyc;
  } exp_t;
  logic clk = 1'b0, rstb = 1'b0;
  logic [RB-1:0] hazard_reg0 = '0;
  logic modifies_flags0 = 1'b0, hazard_1 = 1'b0, hazard_2 = 1'b0, hazard_3 = 1'b0;
  logic mem_stall = 1'b0, flush = 1'b0;
  logic [RB-1:0] hazard_reg1, hazard_reg2, hazard_reg3;
  logic modifies_flags1, modifies_flags2, modifies_flags3;
  logic pipeline_stall, bubble_inserted;
  logic [1:0] stall_state;
  logic [CB-1:0] hazard_stall_count;
  int total = 0, bad = 0, ncyc = 0;
  exp_t sb[$];
  int unsigned pipe[$];
  int unsigned m_bub, m_st, m_cnt;
  always #5 clk = ~clk;
  slurm32_cpu_hazard_pipeline #(.REG_BITS(RB), .CNT_BITS(CB)) dut (
    .CLK(clk), .RSTb(rstb), .hazard_reg0(hazard_reg0), .modifies_flags0(modifies_flags0),
    .hazard_1(hazard_1), .hazard_2(hazard_2), .hazard_3(hazard_3),
    .mem_stall(mem_stall), .flush(flush),
    .hazard_reg1(hazard_reg1), .hazard_reg2(hazard_reg2), .hazard_reg3(hazard_reg3),
    .modifies_flags1(modifies_flags1), .modifies_flags2(modifies_flags2), .modifies_flags3(modifies_flags3),
    .pipeline_stall(pipeline_stall), .bubble_inserted(bubble_inserted),
    .stall_state(stall_state), .hazard_stall_count(hazard_stall_count)
  );
  task automatic chk(input string name, input int cyc, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  // Each pipe entry is tag*2+flag; pipe[0] is stage 1.
  task automatic cyc(input bit rb, input int unsigned tag, input bit fl0, input bit h1, input bit h2,
                     input bit h3, input bit ms, input bit fx);
    exp_t e;
    bit hz;
    @(negedge clk);
    rstb = rb; hazard_reg0 = tag[RB-1:0]; modifies_flags0 = fl0;
    hazard_1 = h1; hazard_2 = h2; hazard_3 = h3; mem_stall = ms; flush = fx;
    hz = h1 | h2 | h3;
    e.stall = (ms || (hz && !fx)) ? 1 : 0;
    if (!rb) begin
      pipe = '{0, 0, 0}; m_bub = 0; m_st = 0; m_cnt = 0;
    end else if (ms) begin
      m_st = 2;
    end else if (fx) begin
      pipe = '{0, 0, pipe[1]}; m_bub = 0; m_st = 0;
    end else if (hz) begin
      pipe.push_front(0); void'(pipe.pop_back());
      m_bub = 1; m_st = 1;
      if (m_cnt < (1 << CB) - 1) m_cnt++;
    end else begin
      pipe.push_front(tag * 2 + fl0); void'(pipe.pop_back());
      m_bub = 0; m_st = 0;
    end
    e.r1 = pipe[0] / 2; e.r2 = pipe[1] / 2; e.r3 = pipe[2] / 2;
    e.f1 = pipe[0] % 2; e.f2 = pipe[1] % 2; e.f3 = pipe[2] % 2;
    e.bub = m_bub; e.st = m_st; e.cnt = m_cnt; e.cyc = ncyc++;
    sb.push_back(e);
  endtask
  task automatic run(input int unsigned tag, input bit h1, input bit h2, input bit h3, input bit ms, input bit fx);
    cyc(1'b1, tag, tag[0], h1, h2, h3, ms, fx);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pipeline_stall", e.cyc, pipeline_stall, e.stall);
        chk("hazard_reg1", e.cyc, hazard_reg1, e.r1);
        chk("hazard_reg2", e.cyc, hazard_reg2, e.r2);
        chk("hazard_reg3", e.cyc, hazard_reg3, e.r3);
        chk("modifies_flags", e.cyc, {modifies_flags1, modifies_flags2, modifies_flags3}, e.f1 * 4 + e.f2 * 2 + e.f3);
        chk("bubble_inserted", e.cyc, bubble_inserted, e.bub);
        chk("stall_state", e.cyc, stall_state, e.st);
        chk("hazard_stall_count", e.cyc, hazard_stall_count, e.cnt);
      end
    end
  end
  initial begin : driver
    pipe = '{0, 0, 0}; m_bub = 0; m_st = 0; m_cnt = 0;
    cyc(1'b0, 8'hAB, 1, 1, 1, 1, 0, 0);
    cyc(1'b0, 8'h5A, 1, 0, 1, 0, 1, 1);
    run(3, 0, 0, 0, 0, 0); run(5, 0, 0, 0, 0, 0); run(7, 0, 0, 0, 0, 0);
    run(4, 0, 0, 0, 0, 0); run(9, 1, 0, 0, 0, 0); run(9, 0, 0, 0, 0, 0);
    run(3, 0, 0, 0, 0, 0); run(5, 0, 0, 0, 0, 0); run(7, 0, 0, 0, 0, 0);
    repeat (3) run(9, 0, 0, 0, 1, 0);
    run(9, 0, 0, 0, 0, 0);
    run(6, 0, 0, 0, 0, 0); run(5, 0, 0, 0, 0, 0); run(4, 0, 0, 0, 0, 0);
    run(11, 0, 1, 0, 0, 1);
    repeat (20) run(2, 1, 0, 0, 0, 0);
    run(13, 1, 0, 0, 1, 1);
    run(13, 0, 0, 0, 0, 1);
    cyc(1'b0, 1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      int unsigned r = $urandom_range(0, 99);
      cyc(r != 0, $urandom_range(0, (1 << RB) - 1), $urandom_range(0, 1),
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0);
    end
    @(negedge clk);
    rstb = 1'b1; mem_stall = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", ncyc, sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
